rgmii_rx_decode: RTL and testbench

RGMII_RX_DECODE -- requirements
Module: rgmii_rx_decode

---
 rtl/rgmii_rx_decode_if.sv | 22 ++
 rtl/rgmii_rx_decode.sv | 185 ++++++++++++++++++
 tb/tb_rgmii_rx_decode.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgmii_rx_decode_if.sv
// RGMII receive-side bus: DDR-captured RXD/RX_CTL nibbles in, GMII byte stream out.
// master drives the RGMII capture side; slave is the decoder.
interface rgmii_rx_decode_if;
  logic [3:0] rx_d1;
  logic [3:0] rx_d2;
  logic       rx_ctl1;
  logic       rx_ctl2;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv;
  logic       gmii_rx_er;
  logic       gmii_rx_valid;

  modport master (
    output rx_d1, rx_d2, rx_ctl1, rx_ctl2,
    input  gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_valid
  );

  modport slave (
    input  rx_d1, rx_d2, rx_ctl1, rx_ctl2,
    output gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_valid
  );
endinterface

// File: rtl/rgmii_rx_decode.sv
// RGMII receive decoder: DDR nibbles to GMII bytes at 10/100/1000M, false-carrier counting.
// Define RGMII_RX_INBAND_STATUS_EN to decode in-band link status from inter-frame idle.
module rgmii_rx_decode #(
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               speed,
  rgmii_rx_decode_if.slave         rx,
  output logic                     link_up,
  output logic [1:0]               link_speed,
  output logic                     full_duplex,
  output logic [ERR_CNT_WIDTH-1:0] false_carrier_count
);

  typedef enum logic {StIdle, StHigh} state_e;

  state_e                   state_q, state_d;
  logic [1:0]               speed_q, speed_d;
  logic [3:0]               low_q, low_d;
  logic                     low_er_q, low_er_d;
  logic                     phase_q, phase_d;
  logic                     armed_q, armed_d;
  logic [7:0]               rxd_q, rxd_d;
  logic                     dv_q, dv_d;
  logic                     er_q, er_d;
  logic                     valid_q, valid_d;
  logic                     fc_q, fc;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     gig;
  logic                     nib_er;

  assign gig    = speed_q[1];
  assign nib_er = rx.rx_ctl1 ^ rx.rx_ctl2;

  // At 1000M both nibbles must carry the false-carrier code; 10/100 looks at rx_d1 only.
  assign fc = ~rx.rx_ctl1 & rx.rx_ctl2 & (rx.rx_d1 == 4'hE) & (~gig | (rx.rx_d2 == 4'hE));

  always_comb begin
    state_d  = state_q;
    low_d    = low_q;
    low_er_d = low_er_q;
    phase_d  = phase_q;
    armed_d  = armed_q | ~rx.rx_ctl1;
    rxd_d    = rxd_q;
    dv_d     = dv_q;
    er_d     = er_q;
    valid_d  = 1'b0;
    speed_d  = (state_q == StIdle && !rx.rx_ctl1) ? speed : speed_q;

    if (gig) begin
      state_d = StIdle;
      phase_d = 1'b0;
      rxd_d   = {rx.rx_d2, rx.rx_d1};
      dv_d    = rx.rx_ctl1;
      er_d    = nib_er;
      valid_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rx.rx_ctl1) begin
            phase_d = 1'b0;
            // Only a frame seen from its start is assembled, so alignment survives a reset.
            if (armed_q) begin
              low_d    = rx.rx_d1;
              low_er_d = nib_er;
              state_d  = StHigh;
            end
          end else begin
            phase_d = ~phase_q;
            if (phase_q) begin
              valid_d = 1'b1;
              rxd_d   = {4'h0, rx.rx_d1};
              dv_d    = 1'b0;
              er_d    = rx.rx_ctl2;
            end
          end
        end
        StHigh: begin
          state_d = StIdle;
          phase_d = 1'b0;
          valid_d = 1'b1;
          dv_d    = 1'b1;
          if (rx.rx_ctl1) begin
            rxd_d = {rx.rx_d1, low_q};
            er_d  = low_er_q | nib_er;
          end else begin
            rxd_d = {4'h0, low_q};
            er_d  = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (fc && !fc_q && !(&cnt_q)) begin
      cnt_d = cnt_q + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      speed_q  <= speed;
      low_q    <= 4'h0;
      low_er_q <= 1'b0;
      phase_q  <= 1'b0;
      armed_q  <= 1'b0;
      rxd_q    <= 8'h00;
      dv_q     <= 1'b0;
      er_q     <= 1'b0;
      valid_q  <= 1'b0;
      fc_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      speed_q  <= speed_d;
      low_q    <= low_d;
      low_er_q <= low_er_d;
      phase_q  <= phase_d;
      armed_q  <= armed_d;
      rxd_q    <= rxd_d;
      dv_q     <= dv_d;
      er_q     <= er_d;
      valid_q  <= valid_d;
      fc_q     <= fc;
      cnt_q    <= cnt_d;
    end
  end

  logic       link_up_q;
  logic [1:0] link_speed_q;
  logic       full_duplex_q;

`ifdef RGMII_RX_INBAND_STATUS_EN
  logic [3:0] st_prev_q;
  logic       st_prev_ok_q;
  logic       st_ok;

  assign st_ok = ~rx.rx_ctl1 & ~rx.rx_ctl2 & (~gig | (rx.rx_d1 == rx.rx_d2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_prev_q     <= 4'h0;
      st_prev_ok_q  <= 1'b0;
      link_up_q     <= 1'b0;
      link_speed_q  <= 2'b00;
      full_duplex_q <= 1'b0;
    end else begin
      st_prev_q    <= rx.rx_d1;
      st_prev_ok_q <= st_ok;
      if (st_ok && st_prev_ok_q && (rx.rx_d1 == st_prev_q)) begin
        link_up_q     <= rx.rx_d1[0];
        link_speed_q  <= rx.rx_d1[2:1];
        full_duplex_q <= rx.rx_d1[3];
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_up_q     <= 1'b0;
      link_speed_q  <= 2'b00;
      full_duplex_q <= 1'b0;
    end else begin
      link_up_q     <= 1'b1;
      link_speed_q  <= speed_d;
      full_duplex_q <= 1'b1;
    end
  end
`endif

  assign rx.gmii_rxd          = rxd_q;
  assign rx.gmii_rx_dv        = dv_q;
  assign rx.gmii_rx_er        = er_q;
  assign rx.gmii_rx_valid     = valid_q;
  assign link_up              = link_up_q;
  assign link_speed           = link_speed_q;
  assign full_duplex          = full_duplex_q;
  assign false_carrier_count  = cnt_q;

endmodule

// File: tb/tb_rgmii_rx_decode.sv
// Scoreboard bench for rgmii_rx_decode: expected frame bytes queued at drive time,
// popped when the decoder emits a data byte; a 2-bit-counter instance checks saturation.
module tb_rgmii_rx_decode;

  logic        clk;
  logic        rst;
  logic [1:0]  speed;
  logic        link_up, full_duplex, link_up2, full_duplex2;
  logic [1:0]  link_speed, link_speed2;
  logic [15:0] fc_cnt;
  logic [1:0]  fc_cnt2;

  rgmii_rx_decode_if bus ();
  rgmii_rx_decode_if bus2 ();

  assign bus2.rx_d1   = bus.rx_d1;
  assign bus2.rx_d2   = bus.rx_d2;
  assign bus2.rx_ctl1 = bus.rx_ctl1;
  assign bus2.rx_ctl2 = bus.rx_ctl2;

  rgmii_rx_decode #(.ERR_CNT_WIDTH(16)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .speed               (speed),
    .rx                  (bus.slave),
    .link_up             (link_up),
    .link_speed          (link_speed),
    .full_duplex         (full_duplex),
    .false_carrier_count (fc_cnt)
  );

  rgmii_rx_decode #(.ERR_CNT_WIDTH(2)) dut_sat (
    .clk                 (clk),
    .rst                 (rst),
    .speed               (speed),
    .rx                  (bus2.slave),
    .link_up             (link_up2),
    .link_speed          (link_speed2),
    .full_duplex         (full_duplex2),
    .false_carrier_count (fc_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] rxd;
    logic       er;
  } exp_t;

  exp_t       q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  logic       hold_ok = 1'b0;
  logic [7:0] hold_rxd = 8'h00;
  int         valid_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] rxd, input logic er);
    exp_t e;
    e.rxd = rxd;
    e.er  = er;
    q.push_back(e);
  endtask

  // Apply one RGMII cycle; returns just after the capturing edge.
  task automatic cyc(input logic [3:0] d1, input logic [3:0] d2, input logic c1, input logic c2);
    bus.rx_d1   = d1;
    bus.rx_d2   = d2;
    bus.rx_ctl1 = c1;
    bus.rx_ctl2 = c2;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_ok = 1'b0;
    end else if (bus.gmii_rx_valid && bus.gmii_rx_dv) begin
      check("sb_nonempty", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("sb_rxd", bus.gmii_rxd, e.rxd);
        check("sb_er", bus.gmii_rx_er, e.er);
        hold_rxd = e.rxd;
        hold_ok  = 1'b1;
      end
    end else if (bus.gmii_rx_valid) begin
      hold_ok = 1'b0;
    end else if (hold_ok) begin
      check("hold_rxd", bus.gmii_rxd, hold_rxd);
      check("hold_dv", bus.gmii_rx_dv, 1);
    end
  end

  initial begin
    rst         = 1'b1;
    speed       = 2'b10;
    bus.rx_d1   = 4'h0;
    bus.rx_d2   = 4'h0;
    bus.rx_ctl1 = 1'b0;
    bus.rx_ctl2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rxd", bus.gmii_rxd, 0);
    check("rst_dv", bus.gmii_rx_dv, 0);
    check("rst_er", bus.gmii_rx_er, 0);
    check("rst_valid", bus.gmii_rx_valid, 0);
    check("rst_link_up", link_up, 0);
    check("rst_link_speed", link_speed, 0);
    check("rst_duplex", full_duplex, 0);
    check("rst_fc", fc_cnt, 0);
    rst = 1'b0;

`ifdef RGMII_RX_INBAND_STATUS_EN
    cyc(4'h0, 4'h0, 1'b0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);
    cyc(4'hD, 4'hD, 1'b0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0, 1'b1);
    check("ib_single_link_up", link_up, 0);
    cyc(4'hD, 4'hD, 1'b0, 1'b0);
    cyc(4'hD, 4'hD, 1'b0, 1'b0);
    check("ib_link_up", link_up, 1);
    check("ib_link_speed", link_speed, 2'b10);
    check("ib_duplex", full_duplex, 1);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0, 1'b1);
    check("ib_keep_link_up", link_up, 1);
    check("ib_keep_speed", link_speed, 2'b10);
`else
    cyc(4'h0, 4'h0, 1'b0, 1'b0);
    check("st_link_up", link_up, 1);
    check("st_link_speed", link_speed, 2'b10);
    check("st_duplex", full_duplex, 1);
`endif

    // 1000M preamble + SFD, then an in-frame error byte
    for (int i = 0; i < 7; i++) push(8'h55, 1'b0);
    push(8'hD5, 1'b0);
    push(8'hA3, 1'b1);
    cyc(4'h5, 4'h5, 1'b1, 1'b1);
    check("lat_rxd", bus.gmii_rxd, 8'h55);
    check("lat_valid", bus.gmii_rx_valid, 1);
    check("lat_dv", bus.gmii_rx_dv, 1);
    for (int i = 0; i < 6; i++) cyc(4'h5, 4'h5, 1'b1, 1'b1);
    cyc(4'h5, 4'hD, 1'b1, 1'b1);
    cyc(4'h3, 4'hA, 1'b1, 1'b0);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);

    // Speed change mid-frame at 1000M applies only after the frame
    for (int i = 0; i < 4; i++) push(8'h21, 1'b0);
    cyc(4'h1, 4'h2, 1'b1, 1'b1);
    cyc(4'h1, 4'h2, 1'b1, 1'b1);
    speed = 2'b01;
    cyc(4'h1, 4'h2, 1'b1, 1'b1);
    cyc(4'h1, 4'h2, 1'b1, 1'b1);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);
`ifndef RGMII_RX_INBAND_STATUS_EN
    check("st_speed_follow", link_speed, 2'b01);
`endif

    // 100M preamble/SFD/data
    push(8'h55, 1'b0);
    push(8'hD5, 1'b0);
    push(8'h21, 1'b0);
    cyc(4'h5, 4'h0, 1'b1, 1'b1);
    cyc(4'h5, 4'h0, 1'b1, 1'b1);
    cyc(4'h5, 4'h0, 1'b1, 1'b1);
    cyc(4'hD, 4'h0, 1'b1, 1'b1);
    cyc(4'h1, 4'h0, 1'b1, 1'b1);
    cyc(4'h2, 4'h0, 1'b1, 1'b1);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);

    // Speed change mid-frame at 100M, then back
    push(8'h21, 1'b0);
    push(8'h43, 1'b0);
    cyc(4'h1, 4'h0, 1'b1, 1'b1);
    speed = 2'b10;
    cyc(4'h2, 4'h0, 1'b1, 1'b1);
    cyc(4'h3, 4'h0, 1'b1, 1'b1);
    cyc(4'h4, 4'h0, 1'b1, 1'b1);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);
    speed = 2'b01;
    cyc(4'h0, 4'h0, 1'b0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);

    // Odd nibble count
    push(8'h21, 1'b0);
    push(8'h03, 1'b1);
    cyc(4'h1, 4'h0, 1'b1, 1'b1);
    cyc(4'h2, 4'h0, 1'b1, 1'b1);
    cyc(4'h3, 4'h0, 1'b1, 1'b1);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);

    // 100M idle: byte strobe every other cycle, er mirrors rx_ctl2
    valid_seen = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(4'h0, 4'h0, 1'b0, 1'b1);
      if (bus.gmii_rx_valid) begin
        valid_seen++;
        check("idle_dv", bus.gmii_rx_dv, 0);
        check("idle_er", bus.gmii_rx_er, 1);
      end
    end
    check("idle_valid_rate", valid_seen, 4);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);

    // In-frame error nibble, then reset while holding a low nibble
    push(8'h87, 1'b1);
    cyc(4'h7, 4'h0, 1'b1, 1'b0);
    cyc(4'h8, 4'h0, 1'b1, 1'b1);
    cyc(4'h5, 4'h0, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    check("mrst_rxd", bus.gmii_rxd, 0);
    check("mrst_dv", bus.gmii_rx_dv, 0);
    check("mrst_er", bus.gmii_rx_er, 0);
    check("mrst_valid", bus.gmii_rx_valid, 0);
    cyc(4'h5, 4'h0, 1'b1, 1'b1);
    rst = 1'b0;
    cyc(4'h5, 4'h0, 1'b1, 1'b1);
    cyc(4'h5, 4'h0, 1'b1, 1'b1);
    check("no_partial_valid", bus.gmii_rx_valid, 0);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);
    push(8'h55, 1'b0);
    cyc(4'h5, 4'h0, 1'b1, 1'b1);
    cyc(4'h5, 4'h0, 1'b1, 1'b1);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);

    // False carrier at 1000M
    speed = 2'b10;
    cyc(4'h0, 4'h0, 1'b0, 1'b0);
    for (int ev = 0; ev < 3; ev++) begin
      cyc(4'hE, 4'hE, 1'b0, 1'b1);
      if (ev == 0) begin
        check("fc_er", bus.gmii_rx_er, 1);
        check("fc_dv", bus.gmii_rx_dv, 0);
      end
      cyc(4'hE, 4'hE, 1'b0, 1'b1);
      cyc(4'h0, 4'h0, 1'b0, 1'b0);
      cyc(4'h0, 4'h0, 1'b0, 1'b0);
    end
    check("fc_count3", fc_cnt, 3);
    check("fc_sat_count3", fc_cnt2, 3);
    cyc(4'hF, 4'hF, 1'b0, 1'b1);
    cyc(4'hF, 4'hF, 1'b0, 1'b1);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);
    cyc(4'hE, 4'hF, 1'b0, 1'b1);
    cyc(4'hE, 4'hF, 1'b0, 1'b1);
    cyc(4'h0, 4'h0, 1'b0, 1'b0);
    check("fc_ext_ignored", fc_cnt, 3);
    for (int ev = 0; ev < 2; ev++) begin
      cyc(4'hE, 4'hE, 1'b0, 1'b1);
      cyc(4'hE, 4'hE, 1'b0, 1'b1);
      cyc(4'h0, 4'h0, 1'b0, 1'b0);
      cyc(4'h0, 4'h0, 1'b0, 1'b0);
    end
    check("fc_count5", fc_cnt, 5);
    check("fc_saturated", fc_cnt2, 3);

    repeat (3) cyc(4'h0, 4'h0, 1'b0, 1'b0);
    check("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
